// File: rtl/spu32_cpu_aluarb.sv
// Two-port arbiter in front of the shared SPU32 ALU: grants one requester, issues the op,
// waits out multi-cycle ops and returns the captured result with a one-cycle done pulse.
module spu32_cpu_aluarb #(
    parameter int RR_ENABLE = 1
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_req0,
    input  logic        I_req1,
    input  logic [3:0]  I_op0,
    input  logic [3:0]  I_op1,
    input  logic [31:0] I_s1_0,
    input  logic [31:0] I_s2_0,
    input  logic [31:0] I_s1_1,
    input  logic [31:0] I_s2_1,
    output logic        O_done0,
    output logic        O_done1,
    output logic [31:0] O_result,
    output logic        O_lt,
    output logic        O_ltu,
    output logic        O_eq,
    output logic        O_alu_en,
    output logic [3:0]  O_alu_op,
    output logic [31:0] O_alu_s1,
    output logic [31:0] O_alu_s2,
    input  logic        I_alu_busy,
    input  logic [31:0] I_alu_data,
    input  logic        I_alu_lt,
    input  logic        I_alu_ltu,
    input  logic        I_alu_eq
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   grant_port;
    logic   last_grant;
    logic   win;

    // Winning port index; only consulted in IDLE when at least one request is up.
    always_comb begin
        win = ~I_req0;
        if (RR_ENABLE != 0 && I_req0 && I_req1)
            win = ~last_grant;
    end

    // Enable follows busy in WAIT so a finished multi-cycle op is never restarted.
    assign O_alu_en = (state == ISSUE) || (state == WAIT && I_alu_busy);

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state      <= IDLE;
            grant_port <= 1'b0;
            last_grant <= 1'b1;
            O_done0    <= 1'b0;
            O_done1    <= 1'b0;
            O_result   <= '0;
            O_lt       <= 1'b0;
            O_ltu      <= 1'b0;
            O_eq       <= 1'b0;
            O_alu_op   <= '0;
            O_alu_s1   <= '0;
            O_alu_s2   <= '0;
        end else begin
            O_done0 <= 1'b0;
            O_done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_req0 || I_req1) begin
                        grant_port <= win;
                        last_grant <= win;
                        O_alu_op   <= win ? I_op1  : I_op0;
                        O_alu_s1   <= win ? I_s1_1 : I_s1_0;
                        O_alu_s2   <= win ? I_s2_1 : I_s2_0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (!I_alu_busy) begin
                        O_result <= I_alu_data;
                        O_lt     <= I_alu_lt;
                        O_ltu    <= I_alu_ltu;
                        O_eq     <= I_alu_eq;
                        O_done0  <= ~grant_port;
                        O_done1  <= grant_port;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spu32_cpu_aluarb.md
SPU32_CPU_ALUARB -- requirements
Module: spu32_cpu_aluarb

Interface
REQ-001 Parameter: RR_ENABLE, default 1, 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.
REQ-002 I_clk  in  1  single clock; all state updates on rising edge.
REQ-003 I_reset  in  1  asynchronous, active-high reset.
REQ-004 I_req0 / I_req1  in  1 each  operation request from port 0 / port 1; held until that port's O_done pulse.
REQ-005 I_op0 / I_op1  in  4 each  ALU opcode from port 0 / port 1, using the codebase ALUOP encoding.
REQ-006 I_s1_0, I_s2_0 / I_s1_1, I_s2_1  in  32 each  operands from port 0 / port 1.
REQ-007 O_done0 / O_done1  out  1 each  one-cycle completion pulse to port 0 / port 1.
REQ-008 O_result  out  32  captured ALU result; valid while any O_done is high, held otherwise.
REQ-009 O_lt, O_ltu, O_eq  out  1 each  captured ALU compare flags; same validity as O_result.
REQ-010 O_alu_en  out  1  ALU enable.
REQ-011 O_alu_op  out  4  registered opcode to the ALU.
REQ-012 O_alu_s1, O_alu_s2  out  32 each  registered operands to the ALU.
REQ-013 I_alu_busy  in  1  ALU busy.
REQ-014 I_alu_data  in  32  ALU result.
REQ-015 I_alu_lt, I_alu_ltu, I_alu_eq  in  1 each  ALU compare flags.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT and DONE; only IDLE accepts requests.
REQ-017 IDLE with any request pending: arbitrate, latch the winner's op/s1/s2 into O_alu_op/s1/s2, record the granted port, go to ISSUE; with no request, stay in IDLE.
REQ-018 Arbitration with RR_ENABLE=1: a sole requester wins; when both request, the port not granted last wins, and the last-granted pointer updates on every grant.
REQ-019 Arbitration with RR_ENABLE=0: port 0 wins whenever I_req0=1.
REQ-020 ISSUE: O_alu_en=1 for exactly one cycle, then go to WAIT unconditionally (I_alu_busy is ignored in ISSUE).
REQ-021 WAIT: O_alu_en = I_alu_busy (combinational), so the ALU never sees enable while idle-after-busy and cannot restart a multi-cycle shift.
REQ-022 WAIT with I_alu_busy=0: register I_alu_data into O_result and the three flags into O_lt/O_ltu/O_eq, then go to DONE; with I_alu_busy=1, stay in WAIT.
REQ-023 DONE: O_alu_en=0; pulse O_done of the granted port for one cycle, then go to IDLE.
REQ-024 Latency: request in IDLE at cycle T gives DONE at T+3 for single-cycle ops, and at T+3+B when I_alu_busy is high for B WAIT cycles (shift by k: B=k+1).
REQ-025 O_alu_op/s1/s2 SHALL stay stable from grant until IDLE is re-entered; requester input changes after grant are ignored.
REQ-026 A request dropped before completion does not abort the operation; the done pulse is still issued.
REQ-027 A request arriving during ISSUE/WAIT/DONE is not lost; it is serviced from the following IDLE cycle onward.
REQ-028 Back-to-back: minimum IDLE occupancy is one cycle between operations.
REQ-029 O_done0 and O_done1 are never high in the same cycle.
REQ-030 There is no timeout; a permanently busy ALU holds WAIT indefinitely.

Reset
REQ-031 Asserting I_reset, at any time including mid-operation, immediately forces: state=IDLE, O_alu_en=0, O_done0/1=0, O_result=0, flags=0, O_alu_op=0 (ADD), operands=0, last-granted pointer=port 1 (so port 0 wins the first contention).
REQ-032 An operation interrupted by reset produces no done pulse; the requester re-requests.

Verification
REQ-033 Port0 ADD s1=5 s2=7, ALU model single-cycle -> O_done0 at T+3, O_result=12; O_alu_en high only in the ISSUE cycle.
REQ-034 Both ports request SUB after reset (p0: 10-3, p1: 1-2) -> p0 served first with 7, then p1 with 0xFFFFFFFF and O_ltu=1, O_lt=1; the sequence repeated alternates p1, p0.
REQ-035 Port1 SLL s1=1 s2=4, busy model high 5 cycles -> O_alu_en high during ISSUE plus the 5 busy cycles only, O_done1 at T+8, O_result=0x10.
REQ-036 RR_ENABLE=0, both ports requesting continuously -> port 0 is granted on every operation; port 1 is never granted.
REQ-037 Reset asserted during WAIT of a shift -> O_alu_en falls asynchronously, no done pulse, state=IDLE; a subsequent request completes normally.
REQ-038 Port0 drops I_req0 during WAIT -> O_done0 is still pulsed; no spurious grant to port 0 afterward.
